branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Sequencer for conditional-branch resolution in the MiniMIPS core.
- Accepts a branch request (BEQ/BNE) from decode.
- Arbitrates for the shared ALU, which performs rs-rt subtraction. The ALU's 32-bit OR-reduce non-zero flag is returned to this block.
- Decides taken/not-taken, computes the target, drives the PC-load and pipeline-flush strobes, and keeps a saturating taken-branch counter.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a taken branch (1..15)
- GNT_TIMEOUT, 8, maximum cycles to wait for ALU grant before aborting (1..255)
- CNT_W, 16, width of taken-branch counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  decode presents a branch
- br_ready  out  1  block can accept a branch
- br_op  in  2  00=BEQ, 01=BNE, 1x=illegal
- pc_plus4  in  32  PC of branch + 4
- imm  in  16  branch offset, in words
- alu_req  out  1  request for the shared ALU (subtract)
- alu_gnt  in  1  ALU granted this cycle; the subtract executes in this cycle
- alu_nonzero  in  1  OR-reduce of the ALU result; valid the cycle after alu_gnt
- pc_load  out  1  one-cycle strobe: load pc_target into PC
- pc_target  out  32  branch target
- flush  out  1  squash younger instructions
- done  out  1  one-cycle strobe: branch resolved (taken or not)
- taken  out  1  resolution result; valid while done=1
- err  out  1  one-cycle strobe: illegal op or grant timeout
- taken_cnt  out  CNT_W  saturating count of taken branches

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except br_ready=1; state=IDLE; latched registers and taken_cnt cleared.
- Mid-operation reset: any state returns to IDLE immediately. No pc_load, flush or done is emitted, and the request is lost.

States:
- IDLE
  - br_ready=1.
  - On br_valid: latch br_op, pc_plus4, imm.
  - If br_op[1]=1: go to ERR.
  - Otherwise go to REQ and clear the timeout counter.
- REQ
  - br_ready=0, alu_req=1.
  - If alu_gnt: go to SAMPLE.
  - Else increment the timeout counter. When it reaches GNT_TIMEOUT without a grant, go to ERR; alu_req drops in the ERR cycle.
- SAMPLE
  - alu_req=0.
  - Compute taken_r = (op==BEQ & ~alu_nonzero) | (op==BNE & alu_nonzero).
  - If taken_r: go to REDIRECT.
  - Else go to DONE.
- REDIRECT
  - pc_load=1 for exactly one cycle.
  - pc_target = pc_plus4_r + (sign-extend(imm_r) << 2), modulo 2^32; wrap-around is allowed, no exception.
  - flush asserts in the same cycle and stays high for FLUSH_CYCLES cycles total, counted by a flush counter.
  - taken_cnt increments by 1 and saturates at all-ones.
  - Go to FLUSH if FLUSH_CYCLES>1, else DONE.
- FLUSH
  - flush=1.
  - When the flush counter expires, go to DONE.
- DONE
  - done=1 and taken=taken_r for one cycle.
  - Go to IDLE.
- ERR
  - err=1 for one cycle.
  - No pc_load, flush or done.
  - Go to IDLE.

Timing and boundary rules:
- Latency, grant in the first REQ cycle:
  - Not-taken: done 3 cycles after acceptance.
  - Taken: done 3+FLUSH_CYCLES cycles after acceptance.
- Back-to-back: br_ready returns to 1 in the cycle after DONE or ERR. No acceptance while busy; br_valid held high is simply accepted at the next IDLE.
- pc_target holds its value after REDIRECT until the next REDIRECT.
- alu_gnt seen outside REQ is ignored.
- imm=0x8000 gives target pc_plus4-0x20000. imm=0x7FFF gives pc_plus4+0x1FFFC.

Test Plan:
- BEQ, imm=0x0004, pc_plus4=0x00400010, grant immediately, alu_nonzero=0 -> pc_load 1 cycle with pc_target=0x00400020; flush high 2 cycles; done=1 with taken=1; taken_cnt=1.
- BNE, alu_nonzero=0 -> no pc_load, no flush; done=1 with taken=0 three cycles after acceptance; taken_cnt unchanged.
- BEQ, imm=0xFFFF, pc_plus4=0x00000000, alu_nonzero=0 -> pc_target=0xFFFFFFFC (wrap).
- br_op=2'b10 -> err pulse; alu_req never asserted; br_ready back to 1 next cycle.
- alu_gnt held 0 with GNT_TIMEOUT=8 -> alu_req high 8 cycles, then err pulse, no done.
- Reset pulsed low during FLUSH -> flush and all strobes drop asynchronously; br_ready=1 after release. Separately: CNT_W=4, 17 taken branches -> taken_cnt saturates at 15.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution sequencer: arbitrates for the shared ALU, decides
// BEQ/BNE outcome, redirects the PC, flushes the pipe and counts taken branches.
module branch_resolve_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int GNT_TIMEOUT  = 8,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [1:0]        br_op,
   input  logic [31:0]       pc_plus4,
   input  logic [15:0]       imm,
   output logic              alu_req,
   input  logic              alu_gnt,
   input  logic              alu_nonzero,
   output logic              pc_load,
   output logic [31:0]       pc_target,
   output logic              flush,
   output logic              done,
   output logic              taken,
   output logic              err,
   output logic [CNT_W-1:0]  taken_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_SAMPLE, S_REDIRECT, S_FLUSH, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] TMO_LAST    = 8'(GNT_TIMEOUT - 1);
   localparam logic [3:0] FL_INIT     = 4'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
   localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

   state_t            state_q;
   logic [1:0]        op_q;
   logic [31:0]       pc_q;
   logic [15:0]       imm_q;
   logic [7:0]        tmo_q;
   logic [3:0]        fl_q;
   logic              taken_r_q;
   logic              br_ready_q, alu_req_q, pc_load_q, flush_q, done_q, taken_q, err_q;
   logic [31:0]       target_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              taken_d;
   logic [31:0]       target_d;
   logic [CNT_W-1:0]  cnt_d;

   // op_q[1] is never set here: illegal ops divert to S_ERR before the ALU is used
   assign taken_d  = ((op_q == 2'b00) & ~alu_nonzero) | ((op_q == 2'b01) & alu_nonzero);
   assign target_d = pc_q + {{14{imm_q[15]}}, imm_q, 2'b00};
   assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         pc_q       <= '0;
         imm_q      <= '0;
         tmo_q      <= '0;
         fl_q       <= '0;
         taken_r_q  <= 1'b0;
         br_ready_q <= 1'b1;
         alu_req_q  <= 1'b0;
         pc_load_q  <= 1'b0;
         flush_q    <= 1'b0;
         done_q     <= 1'b0;
         taken_q    <= 1'b0;
         err_q      <= 1'b0;
         target_q   <= '0;
         cnt_q      <= '0;
      end else begin
         pc_load_q <= 1'b0;
         done_q    <= 1'b0;
         taken_q   <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (br_valid) begin
                  op_q       <= br_op;
                  pc_q       <= pc_plus4;
                  imm_q      <= imm;
                  br_ready_q <= 1'b0;
                  if (br_op[1]) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q   <= S_REQ;
                     tmo_q     <= '0;
                     alu_req_q <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (alu_gnt) begin
                  state_q   <= S_SAMPLE;
                  alu_req_q <= 1'b0;
               end else if (tmo_q == TMO_LAST) begin
                  state_q   <= S_ERR;
                  alu_req_q <= 1'b0;
                  err_q     <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            S_SAMPLE: begin
               taken_r_q <= taken_d;
               if (taken_d) begin
                  state_q   <= S_REDIRECT;
                  pc_load_q <= 1'b1;
                  flush_q   <= 1'b1;
                  target_q  <= target_d;
                  cnt_q     <= cnt_d;
                  fl_q      <= FL_INIT;
               end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_REDIRECT: begin
               if (MULTI_FLUSH) begin
                  state_q <= S_FLUSH;
               end else begin
                  state_q <= S_DONE;
                  flush_q <= 1'b0;
                  done_q  <= 1'b1;
                  taken_q <= taken_r_q;
               end
            end
            S_FLUSH: begin
               if (fl_q == 4'd0) begin
                  state_q <= S_DONE;
                  flush_q <= 1'b0;
                  done_q  <= 1'b1;
                  taken_q <= taken_r_q;
               end else begin
                  fl_q <= fl_q - 4'd1;
               end
            end
            S_DONE, S_ERR: begin
               state_q    <= S_IDLE;
               br_ready_q <= 1'b1;
            end
            default: begin
               state_q    <= S_IDLE;
               br_ready_q <= 1'b1;
               alu_req_q  <= 1'b0;
               flush_q    <= 1'b0;
            end
         endcase
      end
   end

   assign br_ready  = br_ready_q;
   assign alu_req   = alu_req_q;
   assign pc_load   = pc_load_q;
   assign pc_target = target_q;
   assign flush     = flush_q;
   assign done      = done_q;
   assign taken     = taken_q;
   assign err       = err_q;
   assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Randomized bench for branch_resolve_ctrl: two instances (default and a narrow-counter,
// single-flush variant) share stimulus and are checked against a transaction-level model.
module tb_branch_resolve_ctrl;

   localparam int T  = 8;
   localparam int FA = 2;
   localparam int FB = 1;
   localparam int MAXA = 65535;
   localparam int MAXB = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        br_valid = 1'b0;
   logic [1:0]  br_op = '0;
   logic [31:0] pc_plus4 = '0;
   logic [15:0] imm = '0;
   logic        alu_gnt = 1'b0;
   logic        alu_nonzero = 1'b0;

   logic        a_ready, a_req, a_pcl, a_flush, a_done, a_taken, a_err;
   logic [31:0] a_tgt;
   logic [15:0] a_cnt;
   logic        b_ready, b_req, b_pcl, b_flush, b_done, b_taken, b_err;
   logic [31:0] b_tgt;
   logic [3:0]  b_cnt;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.FLUSH_CYCLES(FA), .GNT_TIMEOUT(T), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(a_ready), .br_op(br_op),
      .pc_plus4(pc_plus4), .imm(imm), .alu_req(a_req), .alu_gnt(alu_gnt),
      .alu_nonzero(alu_nonzero), .pc_load(a_pcl), .pc_target(a_tgt), .flush(a_flush),
      .done(a_done), .taken(a_taken), .err(a_err), .taken_cnt(a_cnt));

   branch_resolve_ctrl #(.FLUSH_CYCLES(FB), .GNT_TIMEOUT(T), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(b_ready), .br_op(br_op),
      .pc_plus4(pc_plus4), .imm(imm), .alu_req(b_req), .alu_gnt(alu_gnt),
      .alu_nonzero(alu_nonzero), .pc_load(b_pcl), .pc_target(b_tgt), .flush(b_flush),
      .done(b_done), .taken(b_taken), .err(b_err), .taken_cnt(b_cnt));

   typedef struct packed {
      logic ready, req, pcl, flush, done, taken, err;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   int          cnt_a = 0, cnt_b = 0;
   logic [31:0] tgt_a = '0, tgt_b = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] im);
      int off;
      off = int'($signed(im)) * 4;
      return pc + 32'(off);
   endfunction

   // Cycle (relative to acceptance at cycle 0) of the last busy cycle.
   function automatic int txn_len(input int f, input logic [1:0] op, input int d, input logic nz);
      if (op[1]) return 1;
      if (d >= T) return T + 1;
      if (op[0] == nz) return 3 + d + f;
      return 3 + d;
   endfunction

   function automatic exp_t model(input int f, input int k, input logic [1:0] op,
                                  input int d, input logic nz);
      exp_t e;
      int   l, r, req_end;
      bit   legal, granted, tk;
      l       = txn_len(f, op, d, nz);
      legal   = !op[1];
      granted = legal && (d < T);
      tk      = granted && (op[0] == nz);
      r       = 3 + d;
      req_end = 1 + ((d < T) ? d : T - 1);
      e.ready = (k == 0) || (k > l);
      e.req   = legal && (k >= 1) && (k <= req_end);
      e.err   = op[1] ? (k == 1) : ((d >= T) && (k == T + 1));
      e.pcl   = tk && (k == r);
      e.flush = tk && (k >= r) && (k < r + f);
      e.done  = granted && (k == (tk ? r + f : r));
      e.taken = e.done && tk;
      return e;
   endfunction

   task automatic txn(input logic [1:0] op, input logic [31:0] pc, input logic [15:0] im,
                      input int d, input logic nz, input bit hold);
      int   la, lb, lmax, lmin, win;
      exp_t ea, eb, oa, ob;
      la   = txn_len(FA, op, d, nz);
      lb   = txn_len(FB, op, d, nz);
      lmax = (la > lb) ? la : lb;
      lmin = (la < lb) ? la : lb;
      win  = op[1] ? 0 : 1 + ((d < T) ? d : T - 1);
      for (int k = 0; k <= lmax + 1; k++) begin
         @(posedge clk);
         #1;
         br_valid = (k == 0) || (hold && k <= lmin);
         if (k == 0) begin
            br_op = op; pc_plus4 = pc; imm = im;
         end else begin
            br_op = 2'($urandom); pc_plus4 = $urandom; imm = 16'($urandom);
         end
         if (k >= 1 && k <= win) alu_gnt = (k == 1 + d);
         else                    alu_gnt = 1'($urandom);
         alu_nonzero = (k == 2 + d) ? nz : 1'($urandom);
         @(negedge clk);
         ea = model(FA, k, op, d, nz);
         eb = model(FB, k, op, d, nz);
         if (ea.pcl) begin
            tgt_a = br_target(pc, im);
            cnt_a = (cnt_a < MAXA) ? cnt_a + 1 : MAXA;
         end
         if (eb.pcl) begin
            tgt_b = br_target(pc, im);
            cnt_b = (cnt_b < MAXB) ? cnt_b + 1 : MAXB;
         end
         oa = exp_t'({a_ready, a_req, a_pcl, a_flush, a_done, a_taken, a_err});
         ob = exp_t'({b_ready, b_req, b_pcl, b_flush, b_done, b_taken, b_err});
         chk($sformatf("ctl_a op=%0d d=%0d k=%0d", op, d, k), 32'(oa), 32'(ea));
         chk($sformatf("ctl_b op=%0d d=%0d k=%0d", op, d, k), 32'(ob), 32'(eb));
         chk("tgt_a", a_tgt, tgt_a);
         chk("tgt_b", b_tgt, tgt_b);
         chk("cnt_a", 32'(a_cnt), 32'(cnt_a));
         chk("cnt_b", 32'(b_cnt), 32'(cnt_b));
      end
   endtask

   task automatic reset_in_flush();
      for (int k = 0; k <= 3; k++) begin
         @(posedge clk);
         #1;
         br_valid = (k == 0);
         br_op = 2'b00; pc_plus4 = 32'h0000_1000; imm = 16'h0010;
         alu_gnt = (k == 1);
         alu_nonzero = 1'b0;
      end
      @(negedge clk);
      chk("rst_pre_flush", 32'({a_pcl, a_flush}), 32'b11);
      @(posedge clk);
      #1;
      br_valid = 1'b0;
      chk("rst_in_flush", 32'(a_flush), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_strobes_a", 32'({a_pcl, a_flush, a_done, a_err, a_req}), 32'd0);
      chk("rst_strobes_b", 32'({b_pcl, b_flush, b_done, b_err, b_req}), 32'd0);
      chk("rst_ready", 32'({a_ready, b_ready}), 32'b11);
      chk("rst_cnt", 32'({a_cnt, b_cnt}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_a = 0; cnt_b = 0; tgt_a = '0; tgt_b = '0;
      @(negedge clk);
      chk("rst_release_ready", 32'({a_ready, b_ready, a_flush, a_done}), 32'b1100);
   endtask

   initial begin
      int d;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl_a", 32'({a_ready, a_req, a_pcl, a_flush, a_done, a_taken, a_err}), 32'b1000000);
      chk("reset_ctl_b", 32'({b_ready, b_req, b_pcl, b_flush, b_done, b_taken, b_err}), 32'b1000000);
      chk("reset_tgt", a_tgt, 32'd0);
      chk("reset_cnt", 32'(a_cnt), 32'd0);
      rst_n = 1'b1;

      txn(2'b00, 32'h0040_0010, 16'h0004, 0, 1'b0, 1'b0);
      chk("beq_target", a_tgt, 32'h0040_0020);
      chk("beq_cnt", 32'(a_cnt), 32'd1);
      txn(2'b01, 32'h0040_0100, 16'h0020, 0, 1'b0, 1'b0);
      chk("bne_nt_cnt", 32'(a_cnt), 32'd1);
      txn(2'b00, 32'h0000_0000, 16'hFFFF, 0, 1'b0, 1'b0);
      chk("wrap_target", a_tgt, 32'hFFFF_FFFC);
      txn(2'b10, 32'h1234_5678, 16'h0001, 0, 1'b0, 1'b0);
      txn(2'b11, 32'h1234_5678, 16'h0001, 2, 1'b0, 1'b1);
      txn(2'b00, 32'h0000_2000, 16'h0001, T, 1'b0, 1'b0);
      txn(2'b00, 32'h1000_0000, 16'h8000, 0, 1'b0, 1'b0);
      chk("imm_min_target", a_tgt, 32'h0FFE_0000);
      txn(2'b01, 32'h1000_0000, 16'h7FFF, 3, 1'b1, 1'b1);
      chk("imm_max_target", a_tgt, 32'h1001_FFFC);
      txn(2'b01, 32'h0000_3000, 16'h0004, T - 1, 1'b1, 1'b0);

      reset_in_flush();

      for (int i = 0; i < 300; i++) begin
         d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 2);
         txn(($urandom_range(0, 9) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1)),
             $urandom, 16'($urandom), d, 1'($urandom), 1'($urandom));
      end

      for (int i = 0; i < 17; i++)
         txn(2'b01, $urandom, 16'($urandom), 0, 1'b1, 1'b0);
      chk("sat_cnt_b", 32'(b_cnt), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
